// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the memory bus scheduler and its round-robin pickers.
package mem_sched_pkg;

  localparam int unsigned HOLD_W = 16;

  typedef enum logic [1:0] {IDLE, OWN, GAP} sched_state_t;

  // Index of the first set bit of vec at or after start, wrapping within the low n bits.
  // Returns start when nothing is set; callers qualify with |vec.
  function automatic int unsigned rr_first(input logic [15:0] vec, input int unsigned start,
                                           input int unsigned n);
    int unsigned idx;
    logic        hit;
    rr_first = start;
    hit      = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !hit && vec[idx[3:0]]) begin
        hit      = 1'b1;
        rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mem_bus_scheduler_rr_picker.sv
// Combinational round-robin picker: first eligible index after the last owner, wrapping.
module rr_picker
  import mem_sched_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] last,
  output logic            found,
  output logic [ID_W-1:0] winner
);

  logic [15:0] vec;
  int unsigned start;

  always_comb begin
    vec         = '0;
    vec[N-1:0]  = eligible;
    start       = 32'(last) + 32'd1;
    if (start >= N) start = '0;
    found  = |eligible;
    winner = ID_W'(rr_first(vec, start, N));
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Round-robin owner of the shared memory bus: one grant at a time, one-cycle turnaround,
// and a hold-time watchdog that revokes and reports overlong grants.
module mem_bus_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned       N        = 8,
  parameter logic [HOLD_W-1:0] MAX_HOLD = 16'd64,
  parameter int unsigned       ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            timeout,
  output logic [ID_W-1:0] timeout_id
);

  logic [1:0]        rst_sync;
  logic              rst_n;
  sched_state_t      state;
  logic [ID_W-1:0]   last;
  logic [HOLD_W-1:0] cnt;
  logic [N-1:0]      rearm;
  logic [N-1:0]      rearm_next;
  logic [N-1:0]      eligible;
  logic [N-1:0]      winner_onehot;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic              owner_req;
  logic              hold_limit;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  rr_picker #(.N(N), .ID_W(ID_W)) u_picker (
    .eligible (eligible),
    .last     (last),
    .found    (found),
    .winner   (winner)
  );

  always_comb begin
    eligible                = req & en & rearm;
    winner_onehot           = '0;
    winner_onehot[winner]   = 1'b1;
    owner_req               = req[grant_id];
    hold_limit              = (MAX_HOLD != '0) && (cnt == MAX_HOLD - 1'b1);
    rearm_next              = rearm | ~req;
    // A revoked owner stays ineligible until it is seen with req low.
    if (state == OWN && owner_req && hold_limit) rearm_next[grant_id] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= '0;
      last       <= ID_W'(N - 1);
      cnt        <= '0;
      rearm      <= '1;
    end else begin
      timeout <= 1'b0;
      rearm   <= rearm_next;
      case (state)
        OWN: begin
          // A release on the limit cycle wins over the watchdog.
          if (!owner_req || hold_limit) begin
            state <= GAP;
            grant <= '0;
            busy  <= 1'b0;
            if (owner_req) begin
              timeout    <= 1'b1;
              timeout_id <= grant_id;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (found) begin
            state    <= OWN;
            grant    <= winner_onehot;
            grant_id <= winner;
            busy     <= 1'b1;
            last     <= winner;
            cnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Scoreboard bench for mem_bus_scheduler: a spec-level model predicts grant, release and
// timeout events with their cycle numbers; a negedge monitor pops and compares them.
module tb_mem_bus_scheduler;

  localparam int          N    = 8;
  localparam logic [15:0] MH   = 16'd4;
  localparam int          ID_W = $clog2(N);

  typedef struct {
    int id;
    int cyc;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    en  = '0;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            timeout;
  logic [ID_W-1:0] timeout_id;

  int total = 0;
  int bad   = 0;

  mem_bus_scheduler #(.N(N), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .en         (en),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  ev_t gq[$];
  ev_t rq[$];
  ev_t tq[$];

  int          cyc   = 0;
  int          sync  = 0;
  int          owner = -1;
  int          last  = N - 1;
  int          held  = 0;
  bit          blocked[N];
  logic [N-1:0] req_s = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: DUT event with no predicted event (cycle %0d)", nm, cyc);
  endtask

  task automatic model_reset();
    owner = -1;
    last  = N - 1;
    held  = 0;
    sync  = 0;
    foreach (blocked[i]) blocked[i] = 1'b0;
  endtask

  // Bus ownership as the rules describe it: an owner keeps the bus while requesting, up to
  // MH cycles; a free bus goes to the first eligible client after the previous owner.
  task automatic model_step();
    bit elig[N];
    for (int i = 0; i < N; i++) elig[i] = req[i] && en[i] && !blocked[i];
    for (int i = 0; i < N; i++) if (!req[i]) blocked[i] = 1'b0;
    if (owner >= 0) begin
      if (!req[owner]) begin
        rq.push_back('{owner, cyc});
        owner = -1;
      end else if (MH != 0 && held == int'(MH)) begin
        rq.push_back('{owner, cyc});
        tq.push_back('{owner, cyc});
        blocked[owner] = 1'b1;
        owner = -1;
      end else begin
        held++;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last + k) % N;
        if (elig[i]) begin
          owner = i;
          last  = i;
          held  = 1;
          gq.push_back('{i, cyc});
          break;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      req_s = req;
      if (!rst) model_reset();
      else if (sync < 2) sync++;
      else model_step();
    end
  end

  logic            mon_pb  = 1'b0;
  logic [ID_W-1:0] mon_pid = '0;

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_pb = 1'b0;
      end else begin
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("busy_vs_grant", 32'(busy), 32'(|grant));
        check("grant_without_req", 32'(grant & ~req_s), 32'd0);
        if (busy) check("grant_id_bit", 32'(grant[grant_id]), 32'd1);
        if (busy && !mon_pb) begin
          if (gq.size() == 0) unexpected("grant_start");
          else begin
            e = gq.pop_front();
            check("grant_start_id", 32'(grant_id), e.id);
            check("grant_start_cycle", cyc, e.cyc);
          end
        end
        if (!busy && mon_pb) begin
          if (rq.size() == 0) unexpected("release");
          else begin
            e = rq.pop_front();
            check("release_id", 32'(mon_pid), e.id);
            check("release_cycle", cyc, e.cyc);
          end
        end
        if (timeout) begin
          if (tq.size() == 0) unexpected("timeout");
          else begin
            e = tq.pop_front();
            check("timeout_id", 32'(timeout_id), e.id);
            check("timeout_cycle", cyc, e.cyc);
          end
        end
        mon_pb  = busy;
        mon_pid = grant_id;
      end
    end
  end

  task automatic clear_queues();
    gq.delete();
    rq.delete();
    tq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    en  = '0;
    model_reset();
    clear_queues();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(input string nm, input int maxc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < maxc);
    if (!busy) begin
      total++;
      bad++;
      $display("FAIL %s: busy still 0 after %0d cycles, expected 1", nm, maxc);
    end
  endtask

  initial begin
    int          order[$];
    int          bc;
    int          tc;
    logic        pb;
    logic [N-1:0] r;
    logic [N-1:0] e;

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single request, grant after one edge, release leaves a gap
    en  = '1;
    req = 8'h01;
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'h01);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    req = '0;
    @(negedge clk);
    check("t1_release", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_idle", 32'(grant), 32'd0);

    // 2: everyone requesting, each owner holds three cycles
    do_reset();
    en  = '1;
    req = '1;
    pb  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy && !pb) order.push_back(int'(grant_id));
      pb = busy;
      r  = '1;
      if (owner >= 0 && held >= 3) r[owner] = 1'b0;
      req = r;
    end
    req = '0;
    check("t2_grant_count", 32'(order.size() >= 9), 32'd1);
    for (int k = 0; k < 9; k++)
      if (k < order.size()) check("t2_order", order[k], k % N);

    // 3: watchdog revokes a hog, which must drop req before winning again
    do_reset();
    en  = '1;
    req = 8'h04;
    bc  = 0;
    tc  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (timeout) tc++;
    end
    check("t3_hold_cycles", bc, 4);
    check("t3_timeout_pulses", tc, 1);
    check("t3_timeout_id", 32'(timeout_id), 32'd2);
    req = '0;
    @(negedge clk);
    req = 8'h04;
    wait_busy("t3_regrant", 4);
    check("t3_regrant_grant", 32'(grant), 32'h04);
    req = '0;
    repeat (2) @(negedge clk);

    // 4: enable mask filters arbitration
    do_reset();
    en  = 8'h08;
    req = 8'h0C;
    wait_busy("t4_first", 4);
    check("t4_first_id", 32'(grant_id), 32'd3);
    req = 8'h04;
    en  = 8'h0C;
    @(negedge clk);
    check("t4_gap", 32'(busy), 32'd0);
    wait_busy("t4_second", 4);
    check("t4_second_grant", 32'(grant), 32'h04);
    req = '0;
    repeat (2) @(negedge clk);

    // 5: release on the limit cycle is a normal release
    do_reset();
    en  = '1;
    req = 8'h20;
    bc  = 0;
    tc  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (timeout) tc++;
      if (bc == 4) req = '0;
    end
    check("t5_hold_cycles", bc, 4);
    check("t5_no_timeout", tc, 0);

    // 6: asynchronous reset mid-grant, then client 0 first
    do_reset();
    en  = '1;
    req = 8'h02;
    wait_busy("t6_grant", 4);
    check("t6_owner", 32'(grant_id), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    clear_queues();
    #1;
    check("t6_async_grant", 32'(grant), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_timeout", 32'(timeout), 32'd0);
    req = 8'h03;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_busy("t6_after_reset", 6);
    check("t6_first_priority", 32'(grant_id), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);

    // Random traffic with hogs, mask changes and rearm cases
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r = N'($urandom);
      e = N'($urandom | $urandom | $urandom);
      if (owner >= 0) r[owner] = ($urandom_range(99) < 85);
      req = r;
      en  = e;
    end
    req = '0;
    repeat (8) @(negedge clk);
    check("leftover_grants", gq.size(), 0);
    check("leftover_releases", rq.size(), 0);
    check("leftover_timeouts", tq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

endmodule
